// File: rtl/fw_graph_loader_if.sv
// Bus bundle between fw_graph_loader and its neighbours.
//   Stream in : s_valid, s_ready, s_data (32-bit distance entries)
//   Avalon-MM : m_address, m_byteenable, m_write, m_writedata, m_waitrequest
//   Kernel    : fw_start/fw_busy (call), fw_graph (argument), fw_done/fw_stall (return)
// modport master is the loader's view; modport slave is the environment's view.
interface fw_graph_loader_if #(
    parameter int ADDR_W = 64
) ();
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;

    logic [ADDR_W-1:0] m_address;
    logic [7:0]        m_byteenable;
    logic              m_write;
    logic [63:0]       m_writedata;
    logic              m_waitrequest;

    logic              fw_start;
    logic              fw_busy;
    logic [ADDR_W-1:0] fw_graph;
    logic              fw_done;
    logic              fw_stall;

    modport master (
        input  s_valid, s_data, m_waitrequest, fw_busy, fw_done,
        output s_ready, m_address, m_byteenable, m_write, m_writedata,
               fw_start, fw_graph, fw_stall
    );

    modport slave (
        output s_valid, s_data, m_waitrequest, fw_busy, fw_done,
        input  s_ready, m_address, m_byteenable, m_write, m_writedata,
               fw_start, fw_graph, fw_stall
    );
endinterface

// File: rtl/fw_graph_loader.sv
// fw_graph_loader: loads an N x N distance matrix from a 32-bit stream,
// packs entry pairs into 64-bit words, writes them to memory over an
// Avalon-MM write master, then launches the floydWarshall kernel with the
// matrix base pointer and reports completion with the kernel cycle count.
// Ports:
//   clock, resetn   : clock, asynchronous active-low reset
//   go, base        : start request (IDLE only) and 8-byte aligned base address
//   bus (master)    : stream input, Avalon-MM write master, kernel call/return
//   busy            : high from accepted go until done
//   done            : one-cycle completion pulse
//   kernel_cycles   : cycles from launch acceptance to kernel return
module fw_graph_loader #(
    parameter int N      = 8,
    parameter int ADDR_W = 64
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                go,
    input  logic [ADDR_W-1:0]   base,
    fw_graph_loader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         kernel_cycles
);
    localparam int WORDS = N * N / 2;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_LO, S_LOAD_HI, S_WRITE, S_LAUNCH, S_WAIT, S_FINISH
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       lo;

    // Kernel cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // kernel_cycles doubles as the live counter: cleared on launch accept,
    // counting through WAIT, frozen on return until the next launch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            idx              <= '0;
            base_r           <= '0;
            lo               <= '0;
            bus.s_ready      <= 1'b0;
            bus.m_address    <= '0;
            bus.m_byteenable <= '0;
            bus.m_write      <= 1'b0;
            bus.m_writedata  <= '0;
            bus.fw_start     <= 1'b0;
            bus.fw_graph     <= '0;
            bus.fw_stall     <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            kernel_cycles    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        base_r      <= base;
                        idx         <= '0;
                        busy        <= 1'b1;
                        bus.s_ready <= 1'b1;
                        state       <= S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    if (bus.s_valid) begin
                        lo    <= bus.s_data;
                        state <= S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    // The write request is registered here so it is presented
                    // on the first WRITE cycle with the whole pair in place.
                    if (bus.s_valid) begin
                        bus.s_ready      <= 1'b0;
                        bus.m_write      <= 1'b1;
                        bus.m_address    <= base_r + (ADDR_W'(idx) << 3);
                        bus.m_byteenable <= 8'hFF;
                        bus.m_writedata  <= {bus.s_data, lo};
                        state            <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!bus.m_waitrequest) begin
                        bus.m_write      <= 1'b0;
                        bus.m_byteenable <= 8'h00;
                        if (idx == LAST_IDX) begin
                            bus.fw_start <= 1'b1;
                            bus.fw_graph <= base_r;
                            state        <= S_LAUNCH;
                        end else begin
                            idx         <= idx + 1'b1;
                            bus.s_ready <= 1'b1;
                            state       <= S_LOAD_LO;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (!bus.fw_busy) begin
                        bus.fw_start  <= 1'b0;
                        bus.fw_stall  <= 1'b0;
                        kernel_cycles <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.fw_done) begin
                        bus.fw_stall <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_FINISH;
                    end else begin
                        kernel_cycles <= sat_inc(kernel_cycles);
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fw_graph_loader.sv
// Testbench for fw_graph_loader (N=4): drives the stream, an Avalon slave and
// a kernel model from a cycle loop and compares against a reference built
// from the matrix contents, base address and handshake rules.
module tb_fw_graph_loader;
    localparam int N       = 4;
    localparam int ADDR_W  = 64;
    localparam int WORDS   = N * N / 2;
    localparam int ENTRIES = N * N;

    logic              clock = 1'b0;
    logic              resetn;
    logic              go;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;
    logic [31:0]       kernel_cycles;

    fw_graph_loader_if #(.ADDR_W(ADDR_W)) bus ();

    fw_graph_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .go            (go),
        .base          (base),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .kernel_cycles (kernel_cycles)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string t);
        check({t, ".s_ready"},       bus.s_ready,       0);
        check({t, ".m_write"},       bus.m_write,       0);
        check({t, ".m_address"},     bus.m_address,     0);
        check({t, ".m_writedata"},   bus.m_writedata,   0);
        check({t, ".m_byteenable"},  bus.m_byteenable,  0);
        check({t, ".fw_start"},      bus.fw_start,      0);
        check({t, ".fw_graph"},      bus.fw_graph,      0);
        check({t, ".fw_stall"},      bus.fw_stall,      1);
        check({t, ".busy"},          busy,              0);
        check({t, ".done"},          done,              0);
        check({t, ".kernel_cycles"}, kernel_cycles,     0);
    endtask

    // gap_mode: 0 continuous, 1 every other cycle, 2 random
    // wr_mode : 0 no stall, 1 three-cycle stall on word 2, 2 random
    task automatic run(input logic [ADDR_W-1:0] b, input int gap_mode, input int wr_mode,
                       input int nbusy, input int kdel, input bit go_spam,
                       input bit rst_at5, input bit seq_data);
        logic [31:0] d [ENTRIES];
        logic [63:0] prev_addr, prev_data, exp_data;
        int sent, wr_done, stall_cnt, idx2_cycles, starts, accepts, busy_left, kcyc, dones, cyc;
        bit prev_stalled, finished, aborted, wr;
        for (int i = 0; i < ENTRIES; i++) d[i] = seq_data ? 32'(i) : $urandom;
        sent = 0; wr_done = 0; stall_cnt = 0; idx2_cycles = 0; starts = 0; accepts = 0;
        busy_left = nbusy; kcyc = -1; dones = 0;
        prev_stalled = 0; finished = 0; aborted = 0;
        prev_addr = '0; prev_data = '0;

        @(negedge clock);
        check("idle_busy", busy, 0);
        go = 1'b1; base = b;
        bus.s_valid = 1'b0; bus.fw_busy = 1'b0; bus.fw_done = 1'b0; bus.m_waitrequest = 1'b0;

        for (cyc = 1; cyc <= 3000 && !finished && !aborted; cyc++) begin
            @(negedge clock);
            go   = go_spam && ($urandom_range(0, 2) == 0);
            base = {$urandom, $urandom} & ~64'h7;

            if (done) begin
                dones++;
                finished = 1;
                check("done.busy", busy, 0);
                check("done.kernel_cycles", kernel_cycles, kdel);
                check("done.fw_stall", bus.fw_stall, 1);
                check("done.writes", wr_done, WORDS);
                check("done.accepts", accepts, 1);
                check("done.start_cycles", starts, nbusy + 1);
                if (wr_mode == 1) check("done.idx2_cycles", idx2_cycles, 4);
                if (gap_mode == 0 && wr_mode == 0)
                    check("go_to_done", cyc, 3 * WORDS + 1 + nbusy + kdel + 2);
            end else begin
                check("busy_high", busy, 1);
            end

            // stream source keeps offering beats even after the matrix is sent
            case (gap_mode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = cyc[0];
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = (sent < ENTRIES) ? d[sent] : 32'hDEAD_BEEF;
            if (bus.s_valid && bus.s_ready) sent++;

            // Avalon slave
            if (prev_stalled) begin
                check("stall.m_write", bus.m_write, 1);
                check("stall.m_address", bus.m_address, prev_addr);
                check("stall.m_writedata", bus.m_writedata, prev_data);
            end
            if (bus.m_write) begin
                check("write.s_ready", bus.s_ready, 0);
                if (rst_at5 && wr_done == 5) begin
                    resetn = 1'b0;
                    #1;
                    check_reset_vals("mid_reset");
                    aborted = 1;
                end else begin
                    case (wr_mode)
                        0:       wr = 1'b0;
                        1:       wr = (wr_done == 2 && stall_cnt < 3);
                        default: wr = 1'($urandom_range(0, 1));
                    endcase
                    if (wr) stall_cnt++;
                    if (wr_done == 2) idx2_cycles++;
                    bus.m_waitrequest = wr;
                    if (!wr) begin
                        exp_data = {d[2 * wr_done + 1], d[2 * wr_done]};
                        check("write.m_address", bus.m_address, b + 64'(8 * wr_done));
                        check("write.m_writedata", bus.m_writedata, exp_data);
                        check("write.m_byteenable", bus.m_byteenable, 8'hFF);
                        wr_done++;
                        prev_stalled = 0;
                    end else begin
                        prev_stalled = 1;
                        prev_addr = bus.m_address;
                        prev_data = bus.m_writedata;
                    end
                end
            end else begin
                bus.m_waitrequest = 1'($urandom_range(0, 1));
            end

            if (!aborted) begin
                // kernel: returns after kdel full cycles of waiting
                if (kcyc >= 0) begin
                    check("wait.fw_stall", bus.fw_stall, 0);
                    bus.fw_done = (kcyc == kdel);
                    if (kcyc == kdel) kcyc = -2;
                    else kcyc++;
                end else begin
                    bus.fw_done = 1'b0;
                    check("fw_stall_high", bus.fw_stall, 1);
                end
                // kernel call port
                if (bus.fw_start) begin
                    starts++;
                    check("launch.fw_graph", bus.fw_graph, b);
                    check("launch.after_accept", accepts, 0);
                    if (busy_left > 0) begin
                        bus.fw_busy = 1'b1;
                        busy_left--;
                    end else begin
                        bus.fw_busy = 1'b0;
                        accepts++;
                        kcyc = 0;
                    end
                end else begin
                    bus.fw_busy = 1'b0;
                end
            end
        end

        if (aborted) begin
            @(negedge clock);
            check("reset_hold.busy", busy, 0);
            check("reset_hold.m_write", bus.m_write, 0);
            resetn = 1'b1; go = 1'b0;
            bus.s_valid = 1'b0; bus.fw_done = 1'b0; bus.fw_busy = 1'b0; bus.m_waitrequest = 1'b0;
            return;
        end

        check("done_seen", dones, 1);
        @(negedge clock);
        go = 1'b0; bus.s_valid = 1'b1; bus.fw_done = 1'b0; bus.fw_busy = 1'b0;
        check("post.done", done, 0);
        check("post.busy", busy, 0);
        check("post.s_ready", bus.s_ready, 0);
        check("post.fw_stall", bus.fw_stall, 1);
        check("post.kernel_cycles", kernel_cycles, kdel);
        check("post.beats", sent, ENTRIES);
        @(negedge clock);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b1; go = 1'b0; base = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_waitrequest = 1'b0;
        bus.fw_busy = 1'b0; bus.fw_done = 1'b0;
        #1 resetn = 1'b0;
        #1 check_reset_vals("por");
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        run(64'h1000, 0, 0, 0, 3, 0, 0, 1);
        run(64'h1000, 0, 1, 5, 100, 0, 0, 1);
        run(64'h2000, 1, 0, 0, 7, 1, 0, 1);
        run(64'hFFFF_FFFF_FFFF_FFE0, 0, 0, 2, 0, 0, 0, 0);
        run(64'h3000, 2, 2, 0, 4, 1, 1, 0);
        run(64'h4000, 0, 0, 0, 5, 0, 0, 0);
        for (int r = 0; r < 6; r++)
            run({$urandom, $urandom} & ~64'h7, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 4), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fw_graph_loader.md
Name: fw_graph_loader

Overview:
- Front-end stage that sits directly upstream of the floydWarshall HLS component.
- Accepts an N x N distance matrix as a 32-bit valid/ready stream and packs it two entries per 64-bit word.
- Writes the packed words to shared memory over an Avalon-MM write master, then launches the kernel through its call/return handshake with the matrix base pointer.
- Waits for kernel return and reports completion plus the kernel cycle count.

Parameters:
- N, 8, vertex count; N*N must be even (N even). WORDS = N*N/2.
- ADDR_W, 64, Avalon address width and graph pointer width.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go  in  1  start request; sampled only in IDLE
- base  in  ADDR_W  matrix base byte address, 8-byte aligned, latched on accepted go
- s_valid  in  1  stream entry valid
- s_ready  out  1  stream entry accepted when s_valid & s_ready
- s_data  in  32  distance entry, row-major order
- m_address  out  ADDR_W  write address
- m_byteenable  out  8  byte enables
- m_write  out  1  write request
- m_writedata  out  64  packed pair
- m_waitrequest  in  1  slave stall
- fw_start  out  1  to kernel call.valid
- fw_busy  in  1  from kernel call.stall
- fw_graph  out  ADDR_W  to kernel graph.data
- fw_done  in  1  from kernel return.valid
- fw_stall  out  1  to kernel return.stall
- busy  out  1  high from accepted go until done
- done  out  1  one-cycle completion pulse
- kernel_cycles  out  32  cycles from launch accept to fw_done

Behaviour:
- Reset (async, resetn=0): state=IDLE; idx=0; registers cleared. Output values during reset: s_ready=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0, fw_start=0, fw_graph=0, fw_stall=1, busy=0, done=0, kernel_cycles=0.
- Reset mid-operation returns to IDLE. It does not abort a launched kernel; the kernel's return is held by fw_stall=1.
- IDLE:
  - s_ready=0, busy=0.
  - go=1 latches base into base_r, sets idx=0, moves to LOAD_LO. busy=1 from the next cycle.
- LOAD_LO:
  - s_ready=1.
  - On a stream beat, lo<=s_data and move to LOAD_HI.
- LOAD_HI:
  - s_ready=1.
  - On a stream beat, hi<=s_data and move to WRITE.
- WRITE:
  - s_ready=0, m_write=1, m_address=base_r+8*idx, m_byteenable=8'hFF, m_writedata={hi,lo}.
  - The even entry goes in bits [31:0].
  - All master outputs stay stable while m_waitrequest=1.
  - On m_waitrequest=0 the write completes. If idx==WORDS-1, move to LAUNCH; otherwise idx<=idx+1 and move to LOAD_LO. m_write deasserts the next cycle.
- LAUNCH:
  - fw_start=1, fw_graph=base_r.
  - Accepted on the cycle fw_start & !fw_busy; then kernel_cycles counter <=0 and move to WAIT.
  - fw_start drops the cycle after acceptance.
- WAIT:
  - fw_stall=0; counter increments each cycle and saturates at 32'hFFFFFFFF.
  - On fw_done=1 (consumed that cycle since fw_stall=0), kernel_cycles<=counter and move to FINISH.
- FINISH:
  - done=1 for exactly one cycle, busy=0 the same cycle, then IDLE.
  - kernel_cycles holds until the next accepted launch.
- fw_stall=1 in every state except WAIT.
- go asserted outside IDLE is ignored. go in the FINISH cycle is ignored.
- Latency, zero-wait stream and slave:
  - 3 cycles per word (LO, HI, WRITE).
  - Load phase 3*WORDS cycles after go, then 1 cycle LAUNCH if fw_busy=0.
  - go to done = 3*WORDS + 1 + kernel_cycles + 2.
- s_data beats beyond N*N per run are not accepted (s_ready=0 after the last HI).
- Address arithmetic is modulo 2^ADDR_W. idx width is clog2(WORDS).

Test Plan:
- N=4, base=0x1000, stream 0..15 with no gaps, m_waitrequest=0 -> 8 writes to 0x1000..0x1038, first writedata=0x00000001_00000000, last 0x0000000F_0000000E, byteenable=FF, then fw_start with fw_graph=0x1000.
- Hold m_waitrequest=1 for 3 cycles on write idx 2 -> address 0x1010 and data stable for 4 cycles, one write counted, s_ready=0 throughout.
- fw_busy=1 for 5 cycles in LAUNCH -> fw_start held 6 cycles, single acceptance, WAIT entered after.
- Kernel asserts fw_done 100 cycles after accept -> kernel_cycles=100, done pulses 1 cycle, busy falls, fw_stall back to 1.
- s_valid toggling every other cycle, go pulsed during LOAD -> no spurious word or restart; 8 words written in order.
- resetn low during WRITE idx 5 -> outputs at reset values asynchronously; after release a new go restarts at idx 0 with the new base.
